// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry skid register for a ready/valid pipeline stage.
//               Entries are held in "main" and "skid". in_ready is a pure
//               register output, so out_ready has no combinational path
//               upstream. A flush empties the stage, and it takes priority
//               over any accept or deliver on the same edge.
//               Optional statistics counters (stall_cnt, flush_cnt) are
//               built only when PIPE_SKID_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int                DATA_W     = 97,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic                r_in_ready;
    logic                w_accept;
    logic                w_deliver;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    // A counter width of zero cannot hold any count.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_skid_reg: CNT_W must be at least 1");
    end

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = (r_state != S_EMPTY) & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = (r_state != S_EMPTY) ? r_main : BUBBLE_VAL;

    // Next-state and load-enable decode; flush overrides every handshake.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = S_ONE;
                    end
                end
                S_ONE: begin
                    unique case ({w_deliver, w_accept})
                        2'b11: w_load_main_in = 1'b1;
                        2'b10: w_next_state   = S_EMPTY;
                        2'b01: begin
                            w_load_skid  = 1'b1;
                            w_next_state = S_FULL;
                        end
                        default: w_next_state = S_ONE;
                    endcase
                end
                S_FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (w_deliver) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = S_ONE;
                    end
                end
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    // Occupancy state and registered in_ready, derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_FULL);
        end
    end

    // Payload storage; contents are ignored while the state marks them empty.
    always_ff @(posedge clk) begin
        if (w_load_main_in) begin
            r_main <= in_data;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
        if (w_load_skid) begin
            r_skid <= in_data;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters for stalled cycles and flushes that discard data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && out_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. A queue-based model of
//               the stage is compared against the DUT every cycle, with
//               directed scenarios (streaming, backpressure, flush collision,
//               reset mid-operation, counter saturation) followed by
//               randomized traffic. Counter checks need PIPE_SKID_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int DW = 97;
    localparam int CW = 4;
    localparam logic [DW-1:0] BUB = {1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hC0FF_EE11};
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef PIPE_SKID_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_skid_reg #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two.
    logic [DW-1:0] q[$];
    int            m_stall = 0;
    int            m_flush = 0;

    initial begin : model
        bit vld;
        bit acc;
        bit dlv;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_stall = 0;
                m_flush = 0;
            end else begin
                vld = (q.size() > 0);
                acc = in_valid && (q.size() < 2);
                dlv = vld && out_ready;
                if (vld && !out_ready && m_stall < CNT_MAX) m_stall++;
                if (flush && vld && m_flush < CNT_MAX) m_flush++;
                if (flush) begin
                    q.delete();
                end else begin
                    if (dlv) void'(q.pop_front());
                    if (acc) q.push_back(in_data);
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin : compare
        logic [DW-1:0] exp_data;
        forever begin
            @(negedge clk);
            exp_data = BUB;
            if (q.size() > 0) exp_data = q[0];
            check("out_valid", 128'(out_valid), 128'(q.size() > 0));
            check("out_data", 128'(out_data), 128'(exp_data));
            check("in_ready", 128'(in_ready), 128'(q.size() < 2));
`ifdef PIPE_SKID_STATS_EN
            check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
            check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
`endif
        end
    end

    // Apply one cycle of inputs and return at the following negedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    initial begin : driver
        logic [DW-1:0]  da;
        logic [DW-1:0]  db;
        logic [DW-1:0]  dc;
        logic [127:0]   rnd;
        int             thr;

        da = {1'b0, 32'hAAAA_0001, 32'h1111_2222, 32'h3333_4444};
        db = {1'b1, 32'hBBBB_0002, 32'h5555_6666, 32'h7777_8888};
        dc = {1'b0, 32'hCCCC_0003, 32'h9999_AAAA, 32'hBBBB_CCCC};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", 128'(out_data), 128'(BUB));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        reset = 1'b0;

        // Streaming at one beat per cycle.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0);
            check("stream_data", 128'(out_data), 128'(i));
            check("stream_valid", 128'(out_valid), 128'(1));
            check("stream_in_ready", 128'(in_ready), 128'(1));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("stream_drain", 128'(out_valid), 128'(0));

        // Backpressure: fill both entries, then release.
        step(1'b1, da, 1'b0, 1'b0);
        check("bp_one_data", 128'(out_data), 128'(da));
        check("bp_one_ready", 128'(in_ready), 128'(1));
        step(1'b1, db, 1'b0, 1'b0);
        check("bp_full_ready", 128'(in_ready), 128'(0));
        check("bp_full_data", 128'(out_data), 128'(da));
        step(1'b1, dc, 1'b0, 1'b0);
        check("bp_hold_data", 128'(out_data), 128'(da));
        check("bp_hold_ready", 128'(in_ready), 128'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_second", 128'(out_data), 128'(db));
        check("bp_second_ready", 128'(in_ready), 128'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_empty", 128'(out_valid), 128'(0));

        // Flush collides with an accept and a deliver in FULL.
        step(1'b1, da, 1'b0, 1'b0);
        step(1'b1, db, 1'b0, 1'b0);
        step(1'b1, dc, 1'b1, 1'b1);
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_data", 128'(out_data), 128'(BUB));
        check("flush_ready", 128'(in_ready), 128'(1));
        repeat (3) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("flush_no_stale", 128'(out_valid), 128'(0));
        end

        // Reset pulsed between edges while FULL.
        step(1'b1, da, 1'b0, 1'b0);
        step(1'b1, db, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", 128'(out_valid), 128'(0));
        check("rst_mid_ready", 128'(in_ready), 128'(1));
        check("rst_mid_data", 128'(out_data), 128'(BUB));
        #1 reset = 1'b0;
        @(negedge clk);
        repeat (2) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("rst_no_stale", 128'(out_valid), 128'(0));
        end

        // Counters start from zero after the reset above.
        step(1'b1, da, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STATS_EN
        check("stall_saturate", 128'(stall_cnt), 128'(15));
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, db, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
`ifdef PIPE_SKID_STATS_EN
        check("flush_count", 128'(flush_cnt), 128'(2));
`endif

        // Randomized traffic with varying downstream pressure.
        thr = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) thr = int'($urandom_range(0, 8));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom % 4) != 0, rnd[DW-1:0],
                 int'($urandom % 8) < thr, ($urandom % 40) == 0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
